// File: rtl/rv32i_mem_pkg.sv
// Shared constants and types for the RV32I on-chip memory arbiter:
// memory map, RV32I load/store funct3 codes, FSM states and requester ids.
package rv32i_mem_pkg;

  localparam logic [31:0] IRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] D4K_BASE  = 32'h0000_8000;
  localparam logic [31:0] D2K_BASE  = 32'h0000_C000;
  localparam logic [31:0] MAP_LIMIT = 32'h0000_E000;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_t;

  typedef enum logic [1:0] {
    BANK_NONE,
    BANK_IRAM,
    BANK_D4K,
    BANK_D2K
  } bank_t;

  // Keeps the low 'aw' bits of the shared 13-bit word address.
  function automatic logic [12:0] word_mask(input int unsigned aw);
    logic [12:0] mask;
    for (int i = 0; i < 13; i++) begin
      mask[i] = (i < aw);
    end
    return mask;
  endfunction

endpackage

// File: rtl/rv32i_mem_decode.sv
// Combinational decode of a latched access: bank select, word address,
// byte enables, lane-replicated store data and the reject flag.
module rv32i_mem_decode
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned IRAM_AW = 13,
  parameter int unsigned D4K_AW  = 12,
  parameter int unsigned D2K_AW  = 11
) (
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  req_id_t     id,
  input  logic [31:0] wdata,
  output bank_t       bank,
  output logic [12:0] word_addr,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic        err
);

  logic misalign_w;

  // NOTE: every output gets a default before any branch so no path leaves
  // a combinational signal unassigned, which would otherwise infer a latch.
  always_comb begin
    bank       = BANK_NONE;
    word_addr  = '0;
    be         = 4'b1111;
    lane_wdata = wdata;
    err        = 1'b0;
    misalign_w = |addr[1:0];

    if (addr >= IRAM_BASE && addr < D4K_BASE) begin
      bank = BANK_IRAM;
    end else if (addr < D2K_BASE) begin
      bank = BANK_D4K;
    end else if (addr < MAP_LIMIT) begin
      bank = BANK_D2K;
    end

    case (bank)
      BANK_IRAM: word_addr = addr[14:2] & word_mask(IRAM_AW);
      BANK_D4K:  word_addr = addr[14:2] & word_mask(D4K_AW);
      BANK_D2K:  word_addr = addr[14:2] & word_mask(D2K_AW);
      default:   word_addr = '0;
    endcase

    if (bank == BANK_NONE) begin
      err = 1'b1;
    end

    if (id == REQ_LDR) begin
      if (misalign_w) err = 1'b1;
    end else if (!we) begin
      case (funct3)
        F3_LB, F3_LBU: ;
        F3_LH, F3_LHU: if (addr[0]) err = 1'b1;
        F3_LW:         if (misalign_w) err = 1'b1;
        default:       err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_SB: begin
          be         = 4'b0001 << addr[1:0];
          lane_wdata = {4{wdata[7:0]}};
        end
        F3_SH: begin
          be         = addr[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{wdata[15:0]}};
          if (addr[0]) err = 1'b1;
        end
        F3_SW:   if (misalign_w) err = 1'b1;
        default: err = 1'b1;
      endcase
      // iram holds code images; only the boot loader may write it.
      if (bank == BANK_IRAM) err = 1'b1;
    end
  end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares iram, dram4K and dram2K between the CPU load/store port and the
// boot-loader port: grant, one RAM access cycle, one response cycle.
module rv32i_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter bit          RR_EN   = 1'b1,
  parameter int unsigned IRAM_AW = 13,
  parameter int unsigned D4K_AW  = 12,
  parameter int unsigned D2K_AW  = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_ack,
  output logic        ldr_err,
  output logic [31:0] ldr_rdata,
  output logic [12:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        iram_cs,
  output logic        d4k_cs,
  output logic        d2k_cs,
  input  logic [31:0] iram_rdata,
  input  logic [31:0] d4k_rdata,
  input  logic [31:0] d2k_rdata
);

  state_t      state, state_nx;
  req_id_t     last_grant, grant_id, q_id;
  logic        grant_any;

  logic        q_we;
  logic [31:0] q_addr;
  logic [2:0]  q_funct3;
  logic [31:0] q_wdata;
  bank_t       q_bank;
  logic        q_err;

  bank_t       dec_bank;
  logic [12:0] dec_addr;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;
  logic        dec_err;
  logic [31:0] resp_rdata;

  rv32i_mem_decode #(
    .IRAM_AW (IRAM_AW),
    .D4K_AW  (D4K_AW),
    .D2K_AW  (D2K_AW)
  ) u_decode (
    .we         (q_we),
    .addr       (q_addr),
    .funct3     (q_funct3),
    .id         (q_id),
    .wdata      (q_wdata),
    .bank       (dec_bank),
    .word_addr  (dec_addr),
    .be         (dec_be),
    .lane_wdata (dec_wdata),
    .err        (dec_err)
  );

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_any = cpu_req | ldr_req;
    grant_id  = cpu_req ? REQ_CPU : REQ_LDR;
    if (cpu_req && ldr_req && RR_EN && last_grant == REQ_CPU) begin
      grant_id = REQ_LDR;
    end
  end

  // NOTE: state is written with non-blocking assignments only, so every
  // register samples the pre-edge values and block order cannot matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= REQ_LDR;
      // NOTE: the latched request fields are reset too; they are few flops
      // and this keeps the decode inputs known from the first cycle.
      q_id       <= REQ_CPU;
      q_we       <= 1'b0;
      q_addr     <= '0;
      q_funct3   <= '0;
      q_wdata    <= '0;
      q_bank     <= BANK_NONE;
      q_err      <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && grant_any) begin
        last_grant <= grant_id;
        q_id       <= grant_id;
        if (grant_id == REQ_CPU) begin
          q_we     <= cpu_we;
          q_addr   <= cpu_addr;
          q_funct3 <= cpu_funct3;
          q_wdata  <= cpu_wdata;
        end else begin
          q_we     <= ldr_we;
          q_addr   <= ldr_addr;
          q_funct3 <= ldr_we ? F3_SW : F3_LW;
          q_wdata  <= ldr_wdata;
        end
      end
      if (state == ST_ACCESS) begin
        q_bank <= dec_bank;
        q_err  <= dec_err;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cpu_ack    = 1'b0;
    cpu_err    = 1'b0;
    cpu_rdata  = '0;
    ldr_ack    = 1'b0;
    ldr_err    = 1'b0;
    ldr_rdata  = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    mem_we     = 1'b0;
    iram_cs    = 1'b0;
    d4k_cs     = 1'b0;
    d2k_cs     = 1'b0;
    resp_rdata = '0;

    case (state)
      ST_IDLE: begin
        if (grant_any) state_nx = ST_ACCESS;
      end

      ST_ACCESS: begin
        state_nx = ST_RESP;
        if (!dec_err) begin
          iram_cs   = (dec_bank == BANK_IRAM);
          d4k_cs    = (dec_bank == BANK_D4K);
          d2k_cs    = (dec_bank == BANK_D2K);
          mem_addr  = dec_addr;
          mem_be    = dec_be;
          mem_we    = q_we;
          mem_wdata = q_we ? dec_wdata : '0;
        end
      end

      ST_RESP: begin
        state_nx = ST_IDLE;
        if (!q_err && !q_we) begin
          case (q_bank)
            BANK_IRAM: resp_rdata = iram_rdata;
            BANK_D4K:  resp_rdata = d4k_rdata;
            BANK_D2K:  resp_rdata = d2k_rdata;
            default:   resp_rdata = '0;
          endcase
        end
        if (q_id == REQ_CPU) begin
          cpu_ack   = 1'b1;
          cpu_err   = q_err;
          cpu_rdata = resp_rdata;
        end else begin
          ldr_ack   = 1'b1;
          ldr_err   = q_err;
          ldr_rdata = resp_rdata;
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Cycle-stepped bench: behavioural RAMs, a byte-addressed reference memory
// and a grant/latency model derived from the arbitration rules.
module tb_rv32i_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic        cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic        ldr_req, ldr_we;
  logic [31:0] ldr_addr, ldr_wdata;
  logic        ldr_ack, ldr_err;
  logic [31:0] ldr_rdata;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we, iram_cs, d4k_cs, d2k_cs;
  logic [31:0] iram_rdata, d4k_rdata, d2k_rdata;

  always #5 clk = ~clk;

  rv32i_mem_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_funct3(cpu_funct3),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_err(ldr_err), .ldr_rdata(ldr_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
    .iram_cs(iram_cs), .d4k_cs(d4k_cs), .d2k_cs(d2k_cs),
    .iram_rdata(iram_rdata), .d4k_rdata(d4k_rdata), .d2k_rdata(d2k_rdata)
  );

  // Single-port synchronous RAMs with byte enables and 1-cycle read latency.
  logic [31:0] iram_m [0:8191];
  logic [31:0] d4k_m  [0:4095];
  logic [31:0] d2k_m  [0:2047];
  bit          ram_init;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 8192; i++) iram_m[i] <= '0;
      for (int i = 0; i < 4096; i++) d4k_m[i] <= '0;
      for (int i = 0; i < 2048; i++) d2k_m[i] <= '0;
      ram_init <= 1'b1;
    end else begin
      if (iram_cs) begin
        if (mem_we) iram_m[mem_addr] <= merge(iram_m[mem_addr], mem_wdata, mem_be);
        else        iram_rdata <= iram_m[mem_addr];
      end
      if (d4k_cs) begin
        if (mem_we) d4k_m[mem_addr[11:0]] <= merge(d4k_m[mem_addr[11:0]], mem_wdata, mem_be);
        else        d4k_rdata <= d4k_m[mem_addr[11:0]];
      end
      if (d2k_cs) begin
        if (mem_we) d2k_m[mem_addr[10:0]] <= merge(d2k_m[mem_addr[10:0]], mem_wdata, mem_be);
        else        d2k_rdata <= d2k_m[mem_addr[10:0]];
      end
    end
  end

  typedef struct {
    bit          valid;
    bit          we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          err;
    int          bank;   // 0 none, 1 iram, 2 dram4K, 3 dram2K
    logic [31:0] waddr;
    logic [3:0]  be;
    logic [31:0] wd;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   t        = 0;
  int   free_cyc = 0;
  int   last     = 1;
  bit   chk_en   = 1'b0;
  bit   after_rst;
  txn_t pend [2];
  int   next_ok [2];
  bit   act_v;
  int   act_cyc, act_id;
  txn_t act;
  exp_t act_e;
  logic [7:0] ref_mem [int unsigned];

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, t);
    end
  endtask

  // Expected outcome of an access, straight from the memory map and RV32I rules.
  function automatic exp_t predict(input int id, input txn_t x);
    exp_t        e;
    int unsigned a, off, base;
    a   = x.addr;
    off = a % 4;
    e.bank = (a < 32'h8000) ? 1 : (a < 32'hC000) ? 2 : (a < 32'hE000) ? 3 : 0;
    e.err  = (e.bank == 0);
    if (id == 1) begin
      if (off != 0) e.err = 1'b1;
    end else if (!x.we) begin
      case (x.f3)
        3'd0, 3'd4: ;
        3'd1, 3'd5: if (off % 2 != 0) e.err = 1'b1;
        3'd2:       if (off != 0) e.err = 1'b1;
        default:    e.err = 1'b1;
      endcase
    end else begin
      if (x.f3 > 3'd2) e.err = 1'b1;
      if (x.f3 == 3'd1 && off % 2 != 0) e.err = 1'b1;
      if (x.f3 == 3'd2 && off != 0) e.err = 1'b1;
      if (e.bank == 1) e.err = 1'b1;
    end
    case (e.bank)
      2:       base = 32'h8000;
      3:       base = 32'hC000;
      default: base = 0;
    endcase
    e.waddr = (a - base) / 4;
    e.be    = 4'hF;
    e.wd    = x.wdata;
    if (id == 0 && x.we && x.f3 == 3'd0) begin
      e.be = 4'(1 << off);
      e.wd = {4{x.wdata[7:0]}};
    end
    if (id == 0 && x.we && x.f3 == 3'd1) begin
      e.be = (off >= 2) ? 4'hC : 4'h3;
      e.wd = {2{x.wdata[15:0]}};
    end
    return e;
  endfunction

  function automatic logic [7:0] ref_byte(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int unsigned b;
    b = addr & ~32'd3;
    return {ref_byte(b + 3), ref_byte(b + 2), ref_byte(b + 1), ref_byte(b)};
  endfunction

  task automatic ref_store(input int id, input txn_t x);
    int n;
    n = (id == 1 || x.f3 == 3'd2) ? 4 : (x.f3 == 3'd1) ? 2 : 1;
    for (int i = 0; i < n; i++) ref_mem[x.addr + i] = x.wdata[8*i +: 8];
  endtask

  function automatic txn_t gen_txn(input int r);
    txn_t x;
    x.valid = 1'b1;
    x.we    = $urandom_range(0, 1);
    case ($urandom_range(0, 5))
      0: x.addr = $urandom_range(0, 63);
      1: x.addr = 32'h8000 + $urandom_range(0, 63);
      2: x.addr = 32'hC000 + $urandom_range(0, 63);
      3: case ($urandom_range(0, 2))
           0:       x.addr = 32'h7FFC + $urandom_range(0, 3);
           1:       x.addr = 32'hBFFC + $urandom_range(0, 3);
           default: x.addr = 32'hDFFC + $urandom_range(0, 3);
         endcase
      4: x.addr = 32'hE000 + $urandom_range(0, 255);
      default: x.addr = $urandom();
    endcase
    if ($urandom_range(0, 1) == 1) x.addr = x.addr & ~32'd3;
    if (r == 1 || $urandom_range(0, 3) == 0) begin
      x.f3 = 3'($urandom_range(0, 7));
    end else if (x.we) begin
      x.f3 = 3'($urandom_range(0, 2));
    end else begin
      case ($urandom_range(0, 4))
        0: x.f3 = 3'd0;
        1: x.f3 = 3'd1;
        2: x.f3 = 3'd2;
        3: x.f3 = 3'd4;
        default: x.f3 = 3'd5;
      endcase
    end
    x.wdata = $urandom();
    return x;
  endfunction

  task automatic issue(input int r, input bit we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd);
    pend[r] = '{valid: 1'b1, we: we, addr: addr, f3: f3, wdata: wd};
  endtask

  // One clock cycle: compare outputs, drive requests, advance the model.
  task automatic step(input bit rst_cyc, input bit rnd);
    bit          in_acc, in_rsp, legal;
    int          g;
    logic [31:0] exp_rd;
    @(negedge clk);
    in_acc = act_v && (t == act_cyc + 1);
    in_rsp = act_v && (t == act_cyc + 2);
    legal  = in_acc && !act_e.err;
    if (chk_en) begin
      check("iram_cs", iram_cs, legal && act_e.bank == 1);
      check("d4k_cs",  d4k_cs,  legal && act_e.bank == 2);
      check("d2k_cs",  d2k_cs,  legal && act_e.bank == 3);
      check("mem_we",  mem_we,  legal && act.we);
      if (legal) begin
        check("mem_addr", mem_addr, act_e.waddr);
        check("mem_be",   mem_be,   act_e.be);
        if (act.we) check("mem_wdata", mem_wdata, act_e.wd);
      end
      if (after_rst) begin
        check("rst_mem_be",    mem_be,    0);
        check("rst_cpu_err",   cpu_err,   0);
        check("rst_ldr_err",   ldr_err,   0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_ldr_rdata", ldr_rdata, 0);
      end
      check("cpu_ack", cpu_ack, in_rsp && act_id == 0);
      check("ldr_ack", ldr_ack, in_rsp && act_id == 1);
      if (in_rsp) begin
        exp_rd = act_e.err ? 32'h0 : ref_word(act.addr);
        if (act_id == 0) begin
          check("cpu_err", cpu_err, act_e.err);
          if (!act.we || act_e.err) check("cpu_rdata", cpu_rdata, exp_rd);
        end else begin
          check("ldr_err", ldr_err, act_e.err);
          if (!act.we || act_e.err) check("ldr_rdata", ldr_rdata, exp_rd);
        end
      end
    end
    if (legal && act.we) ref_store(act_id, act);

    rst        = rst_cyc;
    cpu_req    = pend[0].valid;
    cpu_we     = pend[0].valid ? pend[0].we    : 1'($urandom_range(0, 1));
    cpu_addr   = pend[0].valid ? pend[0].addr  : $urandom();
    cpu_funct3 = pend[0].valid ? pend[0].f3    : 3'($urandom_range(0, 7));
    cpu_wdata  = pend[0].valid ? pend[0].wdata : $urandom();
    ldr_req    = pend[1].valid;
    ldr_we     = pend[1].valid ? pend[1].we    : 1'($urandom_range(0, 1));
    ldr_addr   = pend[1].valid ? pend[1].addr  : $urandom();
    ldr_wdata  = pend[1].valid ? pend[1].wdata : $urandom();

    if (in_rsp) begin
      pend[act_id].valid = 1'b0;
      next_ok[act_id]    = t + 2;
      act_v              = 1'b0;
    end

    after_rst = rst_cyc;
    if (rst_cyc) begin
      act_v         = 1'b0;
      pend[0].valid = 1'b0;
      pend[1].valid = 1'b0;
      next_ok[0]    = t + 1;
      next_ok[1]    = t + 1;
      free_cyc      = t + 1;
      last          = 1;
    end else if (t >= free_cyc && (pend[0].valid || pend[1].valid)) begin
      if (pend[0].valid && pend[1].valid) g = (last == 0) ? 1 : 0;
      else                                g = pend[0].valid ? 0 : 1;
      act_v    = 1'b1;
      act_cyc  = t;
      act_id   = g;
      act      = pend[g];
      act_e    = predict(g, act);
      last     = g;
      free_cyc = t + 3;
    end

    if (rnd && !rst_cyc) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r].valid && t + 1 >= next_ok[r] && $urandom_range(0, 2) == 0)
          pend[r] = gen_txn(r);
      end
    end
    t++;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((pend[0].valid || pend[1].valid || act_v) && n < max_cyc) begin
      step(1'b0, 1'b0);
      n++;
    end
    check("drain_done", {31'b0, pend[0].valid || pend[1].valid || act_v}, 0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_funct3 = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    for (int r = 0; r < 2; r++) begin
      pend[r].valid = 1'b0;
      next_ok[r]    = 0;
    end
    act_v = 1'b0;
    step(1'b1, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0);

    // Tie straight after reset: CPU first, loader three cycles later.
    issue(0, 1'b1, 32'h0000_8004, 3'b010, 32'hDEAD_BEEF);
    issue(1, 1'b0, 32'h0000_C000, 3'b000, 32'h0);
    drain(20);
    issue(0, 1'b0, 32'h0000_8004, 3'b010, 32'h0);
    drain(20);
    // CPU won last, so this tie goes to the loader.
    issue(0, 1'b1, 32'h0000_C003, 3'b000, 32'h0000_00A5);
    issue(1, 1'b1, 32'h0000_0010, 3'b111, 32'h1357_9BDF);
    drain(20);
    issue(0, 1'b0, 32'h0000_C000, 3'b010, 32'h0);
    drain(20);
    issue(0, 1'b1, 32'h0000_0010, 3'b010, 32'hFFFF_FFFF);
    drain(20);
    issue(0, 1'b0, 32'h0000_0010, 3'b010, 32'h0);
    drain(20);
    issue(0, 1'b0, 32'h0000_8001, 3'b001, 32'h0);
    drain(20);
    issue(0, 1'b0, 32'h0000_E000, 3'b010, 32'h0);
    drain(20);

    // Reset while a loader write is in its access cycle.
    issue(1, 1'b1, 32'h0000_8010, 3'b000, 32'h1234_5678);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    issue(0, 1'b0, 32'h0000_8010, 3'b010, 32'h0);
    drain(20);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, 1'b1);
    end
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
